// File: rtl/seq_loader.sv
// Sequence loader: pops bytes from a UART receive FIFO, decodes nucleotides and
// writes two '#'-terminated sequences (A then B) into the sequence memory.
module seq_loader #(
    parameter int N       = 8,
    parameter int MAX_LEN = 16,
    parameter int LW      = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          fifo_empty,
    input  logic [N-1:0]  fifo_data,
    output logic          fifo_rd,
    output logic          wr_en,
    output logic          wr_sel,
    output logic [LW-1:0] wr_addr,
    output logic [2:0]    wr_char,
    output logic [LW-1:0] len_a,
    output logic [LW-1:0] len_b,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_POP,
        S_DECODE,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        K_NUC,
        K_TERM,
        K_SKIP,
        K_BAD
    } kind_t;

    localparam logic [N-1:0]  B_G_UP  = N'(8'h47);
    localparam logic [N-1:0]  B_G_LO  = N'(8'h67);
    localparam logic [N-1:0]  B_C_UP  = N'(8'h43);
    localparam logic [N-1:0]  B_C_LO  = N'(8'h63);
    localparam logic [N-1:0]  B_A_UP  = N'(8'h41);
    localparam logic [N-1:0]  B_A_LO  = N'(8'h61);
    localparam logic [N-1:0]  B_T_UP  = N'(8'h54);
    localparam logic [N-1:0]  B_T_LO  = N'(8'h74);
    localparam logic [N-1:0]  B_HASH  = N'(8'h23);
    localparam logic [N-1:0]  B_CR    = N'(8'h0D);
    localparam logic [N-1:0]  B_LF    = N'(8'h0A);
    localparam logic [LW-1:0] IDX_MAX = LW'(MAX_LEN);

    state_t        state_q, state_d;
    logic [LW-1:0] idx_q, idx_d;
    logic          wr_sel_q, wr_sel_d;
    logic          wr_en_q, wr_en_d;
    logic [LW-1:0] wr_addr_q, wr_addr_d;
    logic [2:0]    wr_char_q, wr_char_d;
    logic [LW-1:0] len_a_q, len_a_d;
    logic [LW-1:0] len_b_q, len_b_d;
    logic          err_q, err_d;

    kind_t         kind;
    logic [2:0]    code;

    // Byte classification; case-insensitive nucleotide encoding.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        kind = K_BAD;
        code = 3'b000;
        case (fifo_data)
            B_G_UP, B_G_LO: begin kind = K_NUC; code = 3'b001; end
            B_C_UP, B_C_LO: begin kind = K_NUC; code = 3'b110; end
            B_A_UP, B_A_LO: begin kind = K_NUC; code = 3'b100; end
            B_T_UP, B_T_LO: begin kind = K_NUC; code = 3'b011; end
            B_HASH:         kind = K_TERM;
            B_CR, B_LF:     kind = K_SKIP;
            default:        kind = K_BAD;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wr_sel_d  = wr_sel_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_char_d = wr_char_q;
        len_a_d   = len_a_q;
        len_b_d   = len_b_q;
        err_d     = err_q;
        fifo_rd   = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_POP;
                    idx_d    = '0;
                    wr_sel_d = 1'b0;
                    len_a_d  = '0;
                    len_b_d  = '0;
                    err_d    = 1'b0;
                end
            end

            S_POP: begin
                if (!fifo_empty) begin
                    fifo_rd = 1'b1;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                state_d = S_POP;
                case (kind)
                    K_NUC: begin
                        if (idx_q == IDX_MAX) begin
                            err_d = 1'b1;
                        end else begin
                            // Write and length land on the same edge so they
                            // become visible together.
                            wr_en_d   = 1'b1;
                            wr_addr_d = idx_q;
                            wr_char_d = code;
                            idx_d     = idx_q + 1'b1;
                            if (wr_sel_q) len_b_d = idx_q + 1'b1;
                            else          len_a_d = idx_q + 1'b1;
                        end
                    end
                    K_TERM: begin
                        if (idx_q == '0) err_d = 1'b1;
                        if (!wr_sel_q) begin
                            wr_sel_d = 1'b1;
                            idx_d    = '0;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                    K_SKIP: ;
                    default: err_d = 1'b1;
                endcase
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            wr_sel_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_char_q <= '0;
            len_a_q   <= '0;
            len_b_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples pre-edge values regardless of process ordering.
            state_q   <= state_d;
            idx_q     <= idx_d;
            wr_sel_q  <= wr_sel_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_char_q <= wr_char_d;
            len_a_q   <= len_a_d;
            len_b_q   <= len_b_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        busy = (state_q == S_POP) || (state_q == S_DECODE);
        done = (state_q == S_DONE);
    end

    assign wr_en   = wr_en_q;
    assign wr_sel  = wr_sel_q;
    assign wr_addr = wr_addr_q;
    assign wr_char = wr_char_q;
    assign len_a   = len_a_q;
    assign len_b   = len_b_q;
    assign err     = err_q;

endmodule

// File: doc/seq_loader.md
SEQ_LOADER -- requirements
Module: seq_loader

Interface
REQ-001 SHALL have parameter N, default 8, UART byte width.
REQ-002 SHALL have parameter MAX_LEN, default 16, maximum nucleotides per sequence.
REQ-003 SHALL have parameter LW, default 5, length/address width; the integrator guarantees 2^LW > MAX_LEN.
REQ-004 SHALL have port clk, input, 1, clock; all state on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1, single-cycle pulse that begins a load.
REQ-007 SHALL have port fifo_empty, input, 1, receive FIFO empty flag.
REQ-008 SHALL have port fifo_data, input, N, FIFO read data, valid one cycle after fifo_rd.
REQ-009 SHALL have port fifo_rd, output, 1, FIFO pop strobe.
REQ-010 SHALL have port wr_en, output, 1, sequence-memory write strobe.
REQ-011 SHALL have port wr_sel, output, 1, target sequence (0=A, 1=B).
REQ-012 SHALL have port wr_addr, output, LW, nucleotide index within the sequence.
REQ-013 SHALL have port wr_char, output, 3, encoded nucleotide.
REQ-014 SHALL have port len_a, output, LW, committed length of sequence A.
REQ-015 SHALL have port len_b, output, LW, committed length of sequence B.
REQ-016 SHALL have port busy, output, 1, load in progress.
REQ-017 SHALL have port done, output, 1, both sequences loaded; level output.
REQ-018 SHALL have port err, output, 1, sticky error flag.

Function
REQ-019 SHALL implement FSM states IDLE, POP, DECODE, DONE; busy=1 in POP and DECODE only.
REQ-020 SHALL go IDLE->POP, or DONE->POP, on start; entering POP clears len_a, len_b, err and the write index, and sets wr_sel=0.
REQ-021 SHALL ignore start while busy.
REQ-022 In POP, SHALL assert fifo_rd for exactly one cycle when fifo_empty=0 and then go to DECODE; SHALL wait in POP while fifo_empty=1.
REQ-023 SHALL never assert fifo_rd while fifo_empty=1, and SHALL never hold it for two consecutive cycles.
REQ-024 In DECODE, SHALL sample fifo_data and return to POP, except on the final terminator (REQ-028).
REQ-025 SHALL map case-insensitively: G/g->001, C/c->110, A/a->100, T/t->011.
REQ-026 For a valid nucleotide, SHALL pulse wr_en for one cycle (the cycle after DECODE), with wr_addr equal to the current index and wr_char equal to the code, then increment the index.
REQ-027 SHALL make each write visible in the length output of the active sequence in the same cycle as wr_en.
REQ-028 On '#' (0x23), SHALL close the current sequence; if wr_sel=0, reset the index and set wr_sel=1; if wr_sel=1, go to DONE.
REQ-029 SHALL silently discard CR (0x0D) and LF (0x0A).
REQ-030 On any other byte, SHALL set err, write nothing, and continue.
REQ-031 On a nucleotide arriving when index=MAX_LEN, SHALL set err and drop the nucleotide with no write; indices never wrap.
REQ-032 On '#' with index 0, SHALL set err and commit length 0.
REQ-033 SHALL hold done=1 in DONE until the next start; done=0 in all other states.
REQ-034 SHALL drive wr_en=0 and fifo_rd=0 outside the cycles specified above.

Reset
REQ-035 On rst, SHALL immediately enter IDLE with all outputs 0, including len_a, len_b, err, done, busy, wr_sel, wr_addr and wr_char.
REQ-036 On rst asserted mid-load, SHALL abort the load without a trailing write or pop; after release, SHALL wait for start.

Verification
REQ-037 Bench SHALL cover: start, FIFO "GAT#cc#" -> writes A[0..2]=001,100,011 and B[0..1]=110,110; len_a=3, len_b=2, done=1, err=0.
REQ-038 Bench SHALL cover: "AX\r\nC#G#" -> X sets err; CR/LF discarded; len_a=2, len_b=1, done=1, err=1.
REQ-039 Bench SHALL cover: MAX_LEN+2 'A' followed by "#T#" -> len_a=MAX_LEN, err=1, no write with wr_addr=MAX_LEN.
REQ-040 Bench SHALL cover: FIFO empty for 10 cycles mid-load -> fifo_rd stays 0, busy=1, load resumes when data arrives.
REQ-041 Bench SHALL cover: "##" -> len_a=0, len_b=0, err=1, done=1.
REQ-042 Bench SHALL cover: rst pulsed after two writes -> all outputs 0 next cycle; a later start reloads correctly.
